// File: rtl/watch_mode_ctrl.sv
// -----------------------------------------------------------------------------
// watch_mode_ctrl
//
// Mode sequencer for the four-digit watch/stopwatch. It turns debounced key
// events into mode transitions, command pulses for the watch counter and the
// stopwatch, a display-source select and a per-digit blink mask.
//
// Modes: 0 WATCH, 1 SET_HOUR, 2 SET_MIN, 3 STOPWATCH.
//
// Parameters
//   CLK_HZ          input clock frequency in Hz
//   BLINK_HZ        blink rate of the digits under edit (full on/off period)
//   EDIT_TIMEOUT_S  idle seconds before an edit mode falls back to WATCH
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   key_first_1/2     short-press events (one-cycle pulses)
//   key_long_1/2      long-press events (one-cycle pulses)
//   mode              current mode
//   dsp_sel           1 = watch digits shown, 0 = stopwatch digits
//   blank_mask        bit n blanks Hex_n (1 = digit off)
//   watch_inc_hour    pulse: increment hours
//   watch_inc_min     pulse: increment minutes (no carry)
//   watch_sec_clr     pulse: zero seconds/prescaler on leaving an edit
//   sw_run            level: stopwatch counts while 1
//   sw_clear          pulse: zero the stopwatch
//
// Every output is a register: an event sampled at edge N is visible after
// that edge, and pulses are exactly one cycle wide.
// -----------------------------------------------------------------------------
module watch_mode_ctrl #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int BLINK_HZ       = 2,
  parameter int EDIT_TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_first_1,
  input  logic       key_long_1,
  input  logic       key_first_2,
  input  logic       key_long_2,
  output logic [1:0] mode,
  output logic       dsp_sel,
  output logic [3:0] blank_mask,
  output logic       watch_inc_hour,
  output logic       watch_inc_min,
  output logic       watch_sec_clr,
  output logic       sw_run,
  output logic       sw_clear
);

  // Edit timeout in clock cycles and the blink half-period in clock cycles.
  localparam int TO_CYC     = EDIT_TIMEOUT_S * CLK_HZ;
  localparam int TO_W       = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam int BL_CYC_RAW = CLK_HZ / (2 * BLINK_HZ);
  localparam int BL_CYC     = (BL_CYC_RAW < 1) ? 1 : BL_CYC_RAW;
  localparam int BL_W       = (BL_CYC > 1) ? $clog2(BL_CYC) : 1;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BL_CYC - 1);

  typedef enum logic [1:0] {
    ST_WATCH     = 2'd0,
    ST_SET_HOUR  = 2'd1,
    ST_SET_MIN   = 2'd2,
    ST_STOPWATCH = 2'd3
  } state_t;

  // The single event that wins arbitration this cycle.
  typedef enum logic [2:0] {
    EV_NONE,
    EV_LONG_1,
    EV_FIRST_1,
    EV_LONG_2,
    EV_FIRST_2
  } event_t;

  state_t          r_state;
  logic            r_dsp_sel;
  logic [3:0]      r_blank_mask;
  logic            r_inc_hour;
  logic            r_inc_min;
  logic            r_sec_clr;
  logic            r_sw_run;
  logic            r_sw_clear;
  logic [TO_W-1:0] r_to_cnt;
  logic [BL_W-1:0] r_blink_cnt;
  logic            r_blink_phase;

  event_t          w_ev;
  logic            w_any_key;
  state_t          w_next_state;
  logic            w_next_edit;
  logic            w_state_chg;
  logic            w_inc_hour;
  logic            w_inc_min;
  logic            w_sec_clr;
  logic            w_sw_run;
  logic            w_sw_clear;
  logic            w_blink_restart;
  logic [TO_W-1:0] w_to_next;
  logic [BL_W-1:0] w_blink_cnt_next;
  logic            w_blink_phase_next;
  logic [3:0]      w_blank_mask_next;

  assign w_any_key = key_first_1 | key_long_1 | key_first_2 | key_long_2;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_ev               = EV_NONE;
    w_next_state       = r_state;
    w_inc_hour         = 1'b0;
    w_inc_min          = 1'b0;
    w_sec_clr          = 1'b0;
    w_sw_run           = r_sw_run;
    w_sw_clear         = 1'b0;
    w_to_next          = '0;
    w_blink_cnt_next   = '0;
    w_blink_phase_next = 1'b0;
    w_blank_mask_next  = 4'b0000;

    // Key 1 beats key 2; within a key, long beats first.
    if (key_long_1)       w_ev = EV_LONG_1;
    else if (key_first_1) w_ev = EV_FIRST_1;
    else if (key_long_2)  w_ev = EV_LONG_2;
    else if (key_first_2) w_ev = EV_FIRST_2;

    case (r_state)
      ST_WATCH: begin
        case (w_ev)
          EV_LONG_1: w_next_state = ST_STOPWATCH;
          EV_LONG_2: w_next_state = ST_SET_HOUR;
          default:   ;
        endcase
      end
      ST_SET_HOUR, ST_SET_MIN: begin
        case (w_ev)
          EV_FIRST_2: begin
            if (r_state == ST_SET_HOUR) w_inc_hour = 1'b1;
            else                        w_inc_min  = 1'b1;
          end
          EV_FIRST_1: w_next_state = (r_state == ST_SET_HOUR) ? ST_SET_MIN : ST_SET_HOUR;
          EV_LONG_2: begin
            w_next_state = ST_WATCH;
            w_sec_clr    = 1'b1;
          end
          // Timeout only fires on a cycle with no key activity at all; an
          // ignored key (long 1) still counts as activity.
          EV_NONE: if (r_to_cnt == TO_LAST) w_next_state = ST_WATCH;
          default: ;
        endcase
      end
      ST_STOPWATCH: begin
        case (w_ev)
          EV_FIRST_1: w_sw_run     = ~r_sw_run;
          EV_FIRST_2: w_sw_clear   = ~r_sw_run;
          EV_LONG_1:  w_next_state = ST_WATCH;
          default:    ;
        endcase
      end
      default: ;
    endcase

    w_next_edit = (w_next_state == ST_SET_HOUR) || (w_next_state == ST_SET_MIN);
    w_state_chg = (w_next_state != r_state);

    // Idle counter: advances only while staying in an edit mode untouched.
    if (w_next_edit && !w_state_chg && !w_any_key) w_to_next = r_to_cnt + 1'b1;

    // Blink restarts visible on edit entry and on every increment so the new
    // value is readable straight away.
    w_blink_restart = (w_next_edit && w_state_chg) || w_inc_hour || w_inc_min;
    if (w_next_edit && !w_blink_restart) begin
      if (r_blink_cnt == BL_LAST) begin
        w_blink_cnt_next   = '0;
        w_blink_phase_next = ~r_blink_phase;
      end else begin
        w_blink_cnt_next   = r_blink_cnt + 1'b1;
        w_blink_phase_next = r_blink_phase;
      end
    end

    // Hours live on Hex_3/Hex_2, minutes on Hex_1/Hex_0.
    case (w_next_state)
      ST_SET_HOUR: w_blank_mask_next = {w_blink_phase_next, w_blink_phase_next, 2'b00};
      ST_SET_MIN:  w_blank_mask_next = {2'b00, w_blink_phase_next, w_blink_phase_next};
      default:     w_blank_mask_next = 4'b0000;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_WATCH;
      r_dsp_sel     <= 1'b1;
      r_blank_mask  <= 4'b0000;
      r_inc_hour    <= 1'b0;
      r_inc_min     <= 1'b0;
      r_sec_clr     <= 1'b0;
      r_sw_run      <= 1'b0;
      r_sw_clear    <= 1'b0;
      r_to_cnt      <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_dsp_sel     <= (w_next_state != ST_STOPWATCH);
      r_blank_mask  <= w_blank_mask_next;
      r_inc_hour    <= w_inc_hour;
      r_inc_min     <= w_inc_min;
      r_sec_clr     <= w_sec_clr;
      r_sw_run      <= w_sw_run;
      r_sw_clear    <= w_sw_clear;
      r_to_cnt      <= w_to_next;
      r_blink_cnt   <= w_blink_cnt_next;
      r_blink_phase <= w_blink_phase_next;
    end
  end

  assign mode           = r_state;
  assign dsp_sel        = r_dsp_sel;
  assign blank_mask     = r_blank_mask;
  assign watch_inc_hour = r_inc_hour;
  assign watch_inc_min  = r_inc_min;
  assign watch_sec_clr  = r_sec_clr;
  assign sw_run         = r_sw_run;
  assign sw_clear       = r_sw_clear;

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_watch_mode_ctrl
//
// Scoreboarded bench for watch_mode_ctrl. The driver applies key events on the
// falling edge, steps a behavioural model of the mode rules and pushes the
// expected post-edge output vector into a queue; the monitor pops one entry
// after every rising edge out of reset and compares it with the DUT. Directed
// scenarios add spot checks against fixed values; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_watch_mode_ctrl;

  localparam int CLK_HZ         = 100;
  localparam int BLINK_HZ       = 25;
  localparam int EDIT_TIMEOUT_S = 1;
  localparam int TO_CYCLES      = EDIT_TIMEOUT_S * CLK_HZ;
  localparam int HALF_BLINK     = CLK_HZ / (2 * BLINK_HZ);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_first_1 = 1'b0;
  logic       key_long_1 = 1'b0;
  logic       key_first_2 = 1'b0;
  logic       key_long_2 = 1'b0;
  logic [1:0] mode;
  logic       dsp_sel;
  logic [3:0] blank_mask;
  logic       watch_inc_hour;
  logic       watch_inc_min;
  logic       watch_sec_clr;
  logic       sw_run;
  logic       sw_clear;

  watch_mode_ctrl #(
    .CLK_HZ        (CLK_HZ),
    .BLINK_HZ      (BLINK_HZ),
    .EDIT_TIMEOUT_S(EDIT_TIMEOUT_S)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_first_1   (key_first_1),
    .key_long_1    (key_long_1),
    .key_first_2   (key_first_2),
    .key_long_2    (key_long_2),
    .mode          (mode),
    .dsp_sel       (dsp_sel),
    .blank_mask    (blank_mask),
    .watch_inc_hour(watch_inc_hour),
    .watch_inc_min (watch_inc_min),
    .watch_sec_clr (watch_sec_clr),
    .sw_run        (sw_run),
    .sw_clear      (sw_clear)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] mode;
    logic       dsp;
    logic [3:0] mask;
    logic       inc_hour;
    logic       inc_min;
    logic       sec_clr;
    logic       run;
    logic       clr;
  } out_t;

  out_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   n_inc_hour = 0;
  int   n_inc_min  = 0;
  int   n_sec_clr  = 0;
  int   n_sw_clear = 0;

  // Model state: mode number, run flag, cycles since the last edit activity,
  // cycles since the blink was last restarted.
  int m_mode;
  bit m_run;
  int m_idle;
  int m_blink;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic out_t dut_out();
    out_t o;
    o = {mode, dsp_sel, blank_mask, watch_inc_hour, watch_inc_min,
         watch_sec_clr, sw_run, sw_clear};
    return o;
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_run   = 1'b0;
    m_idle  = 0;
    m_blink = 0;
  endtask

  // Applies the mode rules to one sampled set of key events.
  task automatic model_step(input bit f1, input bit l1, input bit f2, input bit l2);
    bit         any;
    bit         edit;
    bit         ih, im, sc, clr, nr, p;
    int         nm;
    logic [3:0] mask;
    out_t       e;
    any = f1 | l1 | f2 | l2;
    nm  = m_mode;
    ih  = 0; im = 0; sc = 0; clr = 0;
    nr  = m_run;
    // Arbitration applied first: one surviving event per cycle.
    if (l1) begin
      if (m_mode == 0) nm = 3;
      else if (m_mode == 3) nm = 0;
    end else if (f1) begin
      if (m_mode == 1) nm = 2;
      else if (m_mode == 2) nm = 1;
      else if (m_mode == 3) nr = !m_run;
    end else if (l2) begin
      if (m_mode == 0) nm = 1;
      else if (m_mode == 1 || m_mode == 2) begin nm = 0; sc = 1; end
    end else if (f2) begin
      if (m_mode == 1) ih = 1;
      else if (m_mode == 2) im = 1;
      else if (m_mode == 3 && !m_run) clr = 1;
    end else if ((m_mode == 1 || m_mode == 2) && m_idle + 1 == TO_CYCLES) begin
      nm = 0;
    end
    edit = (nm == 1 || nm == 2);
    if (!edit || nm != m_mode || any) m_idle = 0;
    else m_idle = m_idle + 1;
    if (edit && (nm != m_mode || ih || im)) m_blink = 0;
    else if (edit) m_blink = m_blink + 1;
    p = ((m_blink / HALF_BLINK) % 2) == 1;
    if (nm == 1)      mask = {p, p, 2'b00};
    else if (nm == 2) mask = {2'b00, p, p};
    else              mask = 4'b0000;
    e = {2'(nm), (nm != 3), mask, ih, im, sc, nr, clr};
    m_mode = nm;
    m_run  = nr;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit f1, input bit l1, input bit f2, input bit l2);
    @(negedge clk);
    key_first_1 = f1;
    key_long_1  = l1;
    key_first_2 = f2;
    key_long_2  = l2;
    model_step(f1, l1, f2, l2);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0);
  endtask

  // Reads mode just after the edge that consumes the last step's keys.
  task automatic probe_mode(input string name, input int exp);
    @(posedge clk);
    #1;
    check(name, 32'(mode), 32'(exp));
  endtask

  // Asserts reset between edges, checks the asynchronous clear, releases it.
  task automatic do_reset();
    @(negedge clk);
    key_first_1 = 0; key_long_1 = 0; key_first_2 = 0; key_long_2 = 0;
    rst_n = 1'b0;
    #1;
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_dsp_sel", 32'(dsp_sel), 32'd1);
    check("rst_blank_mask", 32'(blank_mask), 32'd0);
    check("rst_sw_run", 32'(sw_run), 32'd0);
    check("rst_pulses", 32'({watch_inc_hour, watch_inc_min, watch_sec_clr, sw_clear}), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    model_step(0, 0, 0, 0);
  endtask

  // Monitor: one expected vector per rising edge out of reset.
  always begin
    @(posedge clk);
    #1;
    if (rst_n === 1'b1) begin
      n_inc_hour += int'(watch_inc_hour);
      n_inc_min  += int'(watch_inc_min);
      n_sec_clr  += int'(watch_sec_clr);
      n_sw_clear += int'(sw_clear);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: got output with no expectation queued (t=%0t)", $time);
      end else begin
        check("cycle_outputs", 32'(dut_out()), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int c_ih, c_im, c_sc, c_clr;
    int pct;
    model_reset();

    do_reset();
    idle(10);

    // Edit sequence: hours x3, switch to minutes, one minute, leave.
    c_ih = n_inc_hour; c_im = n_inc_min; c_sc = n_sec_clr;
    step(0, 0, 0, 1);
    probe_mode("enter_set_hour", 1);
    for (int i = 0; i < 3; i++) begin
      idle(4);
      step(0, 0, 1, 0);
    end
    probe_mode("stay_set_hour", 1);
    idle(4);
    step(1, 0, 0, 0);
    probe_mode("to_set_min", 2);
    idle(4);
    step(0, 0, 1, 0);
    idle(4);
    step(0, 0, 0, 1);
    probe_mode("exit_to_watch", 0);
    check("exit_sec_clr_now", 32'(watch_sec_clr), 32'd1);
    idle(2);
    check("inc_hour_count", 32'(n_inc_hour - c_ih), 32'd3);
    check("inc_min_count", 32'(n_inc_min - c_im), 32'd1);
    check("sec_clr_count", 32'(n_sec_clr - c_sc), 32'd1);

    // Timeout in SET_MIN, restarted by an (ignored) key at idle cycle 60.
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    c_sc = n_sec_clr;
    idle(60);
    step(0, 1, 0, 0);
    idle(99);
    probe_mode("timeout_restarted", 2);
    idle(1);
    probe_mode("timeout_exit", 0);
    idle(2);
    check("timeout_no_sec_clr", 32'(n_sec_clr - c_sc), 32'd0);

    // Stopwatch run/clear behaviour.
    step(0, 1, 0, 0);
    probe_mode("enter_stopwatch", 3);
    check("sw_dsp_sel", 32'(dsp_sel), 32'd0);
    c_clr = n_sw_clear;
    step(1, 0, 0, 0);
    probe_mode("sw_mode_run", 3);
    check("sw_run_on", 32'(sw_run), 32'd1);
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    probe_mode("sw_mode_stop", 3);
    check("sw_run_off", 32'(sw_run), 32'd0);
    step(0, 0, 1, 0);
    idle(2);
    check("sw_clear_count", 32'(n_sw_clear - c_clr), 32'd1);
    step(0, 1, 0, 0);
    probe_mode("sw_exit", 0);
    check("sw_exit_dsp_sel", 32'(dsp_sel), 32'd1);

    // Background run survives leaving and re-entering STOPWATCH.
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    probe_mode("bg_watch", 0);
    check("bg_run_kept", 32'(sw_run), 32'd1);
    step(0, 1, 0, 0);
    probe_mode("bg_back", 3);
    check("bg_run_still", 32'(sw_run), 32'd1);

    // Same-cycle key 1 and key 2 in SET_HOUR: key 2 dropped.
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    c_ih = n_inc_hour;
    step(1, 0, 1, 0);
    probe_mode("prio_to_set_min", 2);
    idle(2);
    check("prio_no_inc_hour", 32'(n_inc_hour - c_ih), 32'd0);

    // Reset in the middle of SET_MIN with the stopwatch running.
    idle(5);
    do_reset();
    idle(5);

    // Randomized phase with varying key density.
    for (int blk = 0; blk < 24; blk++) begin
      case ($urandom_range(0, 3))
        0:       pct = 0;
        1:       pct = 1;
        2:       pct = 4;
        default: pct = 12;
      endcase
      for (int i = 0; i < 150; i++) begin
        step($urandom_range(0, 99) < pct, $urandom_range(0, 99) < pct,
             $urandom_range(0, 99) < pct, $urandom_range(0, 99) < pct);
      end
      if ($urandom_range(0, 7) == 0) do_reset();
    end

    idle(3);
    @(posedge clk);
    #2;
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
